// File: rtl/demux1to2_tdm.sv
// Receive end of a two-channel TDM link: locks onto sync-marked channel-0 slots,
// steers words into per-channel registers, flags slot misalignment and counts pairs.
module demux1to2_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  input  logic               sync,
  output logic [2*WIDTH-1:0] out,
  output logic [1:0]         out_valid,
  output logic               pair_valid,
  output logic               sel,
  output logic               err,
  output logic [7:0]         frames
);

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SLOT0 = 2'd1,
    SLOT1 = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] wr_ch_next;
  logic       pair_next;
  logic       err_set_next;

  logic [1:0] out_valid_reg;
  logic       pair_valid_reg;
  logic       sel_reg;
  logic       err_reg;
  logic [7:0] frames_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ALIGN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Words only move the FSM when in_valid is high; idle cycles freeze everything.
  always_comb begin
    state_next   = state_reg;
    wr_ch_next   = 2'b00;
    pair_next    = 1'b0;
    err_set_next = 1'b0;
    if (in_valid) begin
      case (state_reg)
        ALIGN: begin
          if (sync) begin
            wr_ch_next = 2'b01;
            state_next = SLOT1;
          end
        end
        SLOT1: begin
          if (sync) begin
            // Channel-1 slot missing: resync on the new channel-0 word.
            err_set_next = 1'b1;
            wr_ch_next   = 2'b01;
            state_next   = SLOT1;
          end else begin
            wr_ch_next = 2'b10;
            pair_next  = 1'b1;
            state_next = SLOT0;
          end
        end
        SLOT0: begin
          if (sync) begin
            wr_ch_next = 2'b01;
            state_next = SLOT1;
          end else begin
            err_set_next = 1'b1;
            state_next   = ALIGN;
          end
        end
        default: begin
          state_next = ALIGN;
        end
      endcase
    end
  end

  // Per-channel word registers: each half holds until its channel is rewritten.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [WIDTH-1:0] ch_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ch_reg <= '0;
        end else if (wr_ch_next[gi]) begin
          ch_reg <= in;
        end
      end
      assign out[gi*WIDTH +: WIDTH] = ch_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 2'b00;
      pair_valid_reg <= 1'b0;
      sel_reg        <= 1'b0;
      err_reg        <= 1'b0;
      frames_reg     <= 8'd0;
    end else begin
      out_valid_reg  <= wr_ch_next;
      pair_valid_reg <= pair_next;
      sel_reg        <= (state_next == SLOT1);
      if (err_set_next) begin
        err_reg <= 1'b1;
      end
      if (pair_next) begin
        frames_reg <= frames_reg + 8'd1;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign pair_valid = pair_valid_reg;
  assign sel        = sel_reg;
  assign err        = err_reg;
  assign frames     = frames_reg;

endmodule

// File: tb/tb_demux1to2_tdm.sv
// Randomized and directed bench for demux1to2_tdm against a behavioural
// pending/locked model of the TDM slot rules.
module tb_demux1to2_tdm;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   din;
  logic               in_valid;
  logic               sync;
  logic [2*WIDTH-1:0] dout;
  logic [1:0]         out_valid;
  logic               pair_valid;
  logic               sel;
  logic               err;
  logic [7:0]         frames;

  int checks   = 0;
  int failures = 0;
  int pv_count = 0;

  // Reference model: a ch0 word "pending" its ch1 partner, and whether the link is "locked".
  logic [WIDTH-1:0] m_ch0, m_ch1;
  logic             m_pending, m_locked, m_err;
  logic [1:0]       m_ov;
  logic             m_pv;
  int               m_frames;

  demux1to2_tdm #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .in_valid   (in_valid),
    .sync       (sync),
    .out        (dout),
    .out_valid  (out_valid),
    .pair_valid (pair_valid),
    .sel        (sel),
    .err        (err),
    .frames     (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] w);
    m_ov = 2'b00;
    m_pv = 1'b0;
    if (r) begin
      m_ch0 = '0; m_ch1 = '0; m_pending = 0; m_locked = 0; m_err = 0; m_frames = 0;
    end else if (v) begin
      if (s) begin
        if (m_pending) m_err = 1'b1;
        m_ch0 = w; m_ov = 2'b01; m_pending = 1'b1; m_locked = 1'b1;
      end else if (m_pending) begin
        m_ch1 = w; m_ov = 2'b10; m_pv = 1'b1; m_pending = 1'b0;
        m_frames = (m_frames + 1) % 256;
      end else if (m_locked) begin
        m_err = 1'b1; m_locked = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] w, input bit verbose);
    @(negedge clk);
    rst = r; in_valid = v; sync = s; din = w;
    @(posedge clk);
    #1;
    model_update(r, v, s, w);
    if (pair_valid === 1'b1) pv_count++;
    check("out",        {16'd0, dout},        {16'd0, m_ch1, m_ch0});
    check("out_valid",  {30'd0, out_valid},   {30'd0, m_ov});
    check("pair_valid", {31'd0, pair_valid},  {31'd0, m_pv});
    check("sel",        {31'd0, sel},         {31'd0, m_pending});
    check("err",        {31'd0, err},         {31'd0, m_err});
    check("frames",     {24'd0, frames},      m_frames);
    if (verbose)
      $display("txn rst=%0b v=%0b s=%0b in=%02h -> out=%04h ov=%0b pv=%0b sel=%0b err=%0b frames=%0d",
               r, v, s, w, dout, out_valid, pair_valid, sel, err, frames);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic reset_dut;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sync = 1'b0; din = '0;
    m_ch0 = '0; m_ch1 = '0; m_pending = 0; m_locked = 0; m_err = 0; m_frames = 0;
    m_ov = 0; m_pv = 0;

    // Reset state
    reset_dut();
    check("reset_out", {16'd0, dout}, 32'h0);

    // Aligned back-to-back stream
    step(0, 1, 1, 8'hA5, 1);
    step(0, 1, 0, 8'h3C, 1);
    check("plan1_pair", {16'd0, dout}, 32'h3CA5);
    step(0, 1, 1, 8'h11, 1);
    step(0, 1, 0, 8'h22, 1);
    check("plan1_out", {16'd0, dout}, 32'h2211);
    check("plan1_frames", {24'd0, frames}, 32'd2);

    // Leading garbage then gaps
    reset_dut();
    step(0, 1, 0, 8'h77, 1);
    step(0, 1, 0, 8'h88, 1);
    step(0, 1, 1, 8'hA5, 1);
    idle(3);
    check("plan2_sel_idle", {31'd0, sel}, 32'd1);
    step(0, 1, 0, 8'h3C, 1);
    check("plan2_out", {16'd0, dout}, 32'h3CA5);

    // Missing channel-1 slot
    reset_dut();
    pv_count = 0;
    step(0, 1, 1, 8'h01, 1);
    step(0, 1, 1, 8'h02, 1);
    check("plan3_err", {31'd0, err}, 32'd1);
    step(0, 1, 0, 8'h03, 1);
    check("plan3_out", {16'd0, dout}, 32'h0302);
    check("plan3_pv_count", pv_count, 32'd1);

    // Missing sync in SLOT0
    reset_dut();
    step(0, 1, 1, 8'h10, 1);
    step(0, 1, 0, 8'h20, 1);
    step(0, 1, 0, 8'h55, 1);
    check("plan4_out_held", {16'd0, dout}, 32'h2010);
    step(0, 1, 1, 8'h66, 1);
    step(0, 1, 0, 8'h77, 1);
    check("plan4_out", {16'd0, dout}, 32'h7766);
    check("plan4_err_sticky", {31'd0, err}, 32'd1);

    // Frame counter wrap, then reset mid-frame with a word presented
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 1, 8'(i), 0);
      step(0, 1, 0, 8'(255 - i), 0);
    end
    check("wrap_frames", {24'd0, frames}, 32'd0);
    step(0, 1, 1, 8'h9A, 1);
    step(1, 1, 0, 8'hBC, 1);
    check("rst_out", {16'd0, dout}, 32'h0);
    step(0, 1, 0, 8'hDE, 1);
    check("rst_discard", {30'd0, out_valid}, 32'd0);

    // Randomized stream with occasional slot errors, gaps and resets
    for (int i = 0; i < 3000; i++) begin
      logic r, v, s;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = !m_pending;
      if ($urandom_range(0, 9) == 0) s = !s;
      step(r, v, s, 8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
